// File: rtl/fp_add_arbiter.sv
// fp_add_arbiter
// Shares one multi-cycle single-precision add datapath between two requesters.
// A round-robin arbiter picks a requester and latches its operand pair. The
// block then either resolves the sum directly (zero-operand bypass) or
// launches the datapath and waits for it under a watchdog. The tagged result
// leaves through one response channel that honours backpressure.
//
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   r0_valid/r0_ready/r0_a/r0_b  requester 0 operand channel
//   r1_valid/r1_ready/r1_a/r1_b  requester 1 operand channel
//   dp_start, dp_a, dp_b       datapath launch pulse and held operands
//   dp_done, dp_result         datapath completion pulse and sum
//   resp_valid/resp_ready      response handshake
//   resp_data, resp_id, resp_err  sum, issuing requester, timeout flag
module fp_add_arbiter #(
  parameter int W       = 32,
  parameter int TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         r0_valid,
  output logic         r0_ready,
  input  logic [W-1:0] r0_a,
  input  logic [W-1:0] r0_b,
  input  logic         r1_valid,
  output logic         r1_ready,
  input  logic [W-1:0] r1_a,
  input  logic [W-1:0] r1_b,
  output logic         dp_start,
  output logic [W-1:0] dp_a,
  output logic [W-1:0] dp_b,
  input  logic         dp_done,
  input  logic [W-1:0] dp_result,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic [W-1:0] resp_data,
  output logic         resp_id,
  output logic         resp_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [W-1:0] QNAN = 32'h7FC0_0000;
  // WAIT starts with the counter at 0, so the last allowed WAIT cycle (the one
  // TIMEOUT-1 cycles after dp_start) sees the counter at TIMEOUT-2.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 2);

  // Zero means exponent and fraction both clear; the sign is ignored.
  function automatic logic is_zero(input logic [W-1:0] x);
    return (x[W-2:0] == {(W-1){1'b0}});
  endfunction

  // Sum when at least one operand is zero. Two zeros give -0 only if both
  // are -0 (round-to-nearest).
  function automatic logic [W-1:0] bypass_sum(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r;
    if (is_zero(a) && is_zero(b)) begin
      r = {a[W-1] & b[W-1], {(W-1){1'b0}}};
    end else if (is_zero(a)) begin
      r = b;
    end else begin
      r = a;
    end
    return r;
  endfunction

  state_t       state_r, state_s;
  logic         ptr_r, ptr_s;          // requester favoured on contention
  logic         id_r, id_s;
  logic [W-1:0] dp_a_r, dp_a_s;
  logic [W-1:0] dp_b_r, dp_b_s;
  logic         dp_start_r, dp_start_s;
  logic [7:0]   cnt_r, cnt_s;
  logic         resp_valid_r, resp_valid_s;
  logic [W-1:0] resp_data_r, resp_data_s;
  logic         resp_err_r, resp_err_s;

  logic         grant_any_s, grant_id_s;
  logic [W-1:0] gnt_a_s, gnt_b_s;

  // Round-robin arbitration, only meaningful while idle.
  always_comb begin
    grant_any_s = 1'b0;
    grant_id_s  = 1'b0;
    if (state_r == IDLE) begin
      if (r0_valid && r1_valid) begin
        grant_any_s = 1'b1;
        grant_id_s  = ptr_r;
      end else if (r0_valid) begin
        grant_any_s = 1'b1;
        grant_id_s  = 1'b0;
      end else if (r1_valid) begin
        grant_any_s = 1'b1;
        grant_id_s  = 1'b1;
      end else begin
        grant_any_s = 1'b0;
      end
    end else begin
      grant_any_s = 1'b0;
    end
    gnt_a_s = grant_id_s ? r1_a : r0_a;
    gnt_b_s = grant_id_s ? r1_b : r0_b;
  end

  // Readies are held low while reset is asserted so all outputs read 0.
  assign r0_ready = grant_any_s & ~grant_id_s & ~rst;
  assign r1_ready = grant_any_s &  grant_id_s & ~rst;

  // Next-state and next-register values for the control FSM.
  always_comb begin
    state_s      = state_r;
    ptr_s        = ptr_r;
    id_s         = id_r;
    dp_a_s       = dp_a_r;
    dp_b_s       = dp_b_r;
    dp_start_s   = 1'b0;
    cnt_s        = cnt_r;
    resp_valid_s = resp_valid_r;
    resp_data_s  = resp_data_r;
    resp_err_s   = resp_err_r;
    case (state_r)
      IDLE: begin
        if (grant_any_s) begin
          ptr_s  = ~grant_id_s;
          id_s   = grant_id_s;
          dp_a_s = gnt_a_s;
          dp_b_s = gnt_b_s;
          if (is_zero(gnt_a_s) || is_zero(gnt_b_s)) begin
            state_s      = RESP;
            resp_valid_s = 1'b1;
            resp_data_s  = bypass_sum(gnt_a_s, gnt_b_s);
            resp_err_s   = 1'b0;
          end else begin
            state_s    = ISSUE;
            dp_start_s = 1'b1;   // registered, so the pulse lands in ISSUE
          end
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: begin
        cnt_s   = 8'd0;
        state_s = WAIT;
      end
      WAIT: begin
        if (dp_done) begin
          state_s      = RESP;
          resp_valid_s = 1'b1;
          resp_data_s  = dp_result;
          resp_err_s   = 1'b0;
        end else if (cnt_r == CNT_LAST) begin
          state_s      = RESP;
          resp_valid_s = 1'b1;
          resp_data_s  = QNAN;
          resp_err_s   = 1'b1;
        end else begin
          cnt_s = cnt_r + 8'd1;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_s      = IDLE;
          resp_valid_s = 1'b0;
        end else begin
          state_s = RESP;
        end
      end
      default: begin
        state_s      = IDLE;
        resp_valid_s = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      ptr_r        <= 1'b0;
      id_r         <= 1'b0;
      dp_a_r       <= '0;
      dp_b_r       <= '0;
      dp_start_r   <= 1'b0;
      cnt_r        <= 8'd0;
      resp_valid_r <= 1'b0;
      resp_data_r  <= '0;
      resp_err_r   <= 1'b0;
    end else begin
      state_r      <= state_s;
      ptr_r        <= ptr_s;
      id_r         <= id_s;
      dp_a_r       <= dp_a_s;
      dp_b_r       <= dp_b_s;
      dp_start_r   <= dp_start_s;
      cnt_r        <= cnt_s;
      resp_valid_r <= resp_valid_s;
      resp_data_r  <= resp_data_s;
      resp_err_r   <= resp_err_s;
    end
  end

  assign dp_start   = dp_start_r;
  assign dp_a       = dp_a_r;
  assign dp_b       = dp_b_r;
  assign resp_valid = resp_valid_r;
  assign resp_data  = resp_data_r;
  assign resp_id    = id_r;
  assign resp_err   = resp_err_r;

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Directed testbench for fp_add_arbiter. The bench plays the datapath itself,
// driving dp_done/dp_result at hand-chosen cycles.
module tb_fp_add_arbiter;

  logic        clk;
  logic        rst;
  logic        r0_valid, r0_ready, r1_valid, r1_ready;
  logic [31:0] r0_a, r0_b, r1_a, r1_b;
  logic        dp_start, dp_done;
  logic [31:0] dp_a, dp_b, dp_result;
  logic        resp_valid, resp_ready, resp_id, resp_err;
  logic [31:0] resp_data;

  int total = 0;
  int bad   = 0;

  fp_add_arbiter #(.W(32), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_a(r0_a), .r0_b(r0_b),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_a(r1_a), .r1_b(r1_b),
    .dp_start(dp_start), .dp_a(dp_a), .dp_b(dp_b),
    .dp_done(dp_done), .dp_result(dp_result),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_id(resp_id), .resp_err(resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; r0_valid = 1'b1; r1_valid = 1'b1; resp_ready = 1'b1;
    r0_a = 32'h3F80_0000; r0_b = 32'h3F80_0000; r1_a = 32'h4000_0000; r1_b = 32'h4000_0000;
    dp_done = 1'b0; dp_result = 32'h0;
    #12;
    total++; if ({r0_ready, r1_ready} !== 2'b00) begin bad++; $display("FAIL reset_ready got %b want 00", {r0_ready, r1_ready}); end
    total++; if ({dp_start, resp_valid, resp_id, resp_err} !== 4'b0000) begin bad++; $display("FAIL reset_ctrl got %b want 0000", {dp_start, resp_valid, resp_id, resp_err}); end
    total++; if ({dp_a, dp_b, resp_data} !== 96'h0) begin bad++; $display("FAIL reset_data got %h want 0", {dp_a, dp_b, resp_data}); end
    r0_valid = 1'b0; r1_valid = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_contention();
    int waited;
    logic got_id;
    logic [31:0] exp_data;
    r0_valid = 1'b1; r1_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      waited = 0;
      #1;
      while (!(r0_ready || r1_ready) && waited < 10) begin tick(); #1; waited++; end
      total++; if (waited >= 10) begin bad++; $display("FAIL contention_wait op %0d got no grant want grant", i); end
      got_id = r1_ready;
      total++; if (got_id !== i[0]) begin bad++; $display("FAIL contention_grant op %0d got %b want %b", i, got_id, i[0]); end
      tick();                       // ISSUE
      tick();                       // first WAIT cycle
      exp_data = 32'h1111_0000 + 32'(i);
      dp_done = 1'b1; dp_result = exp_data;
      tick();
      dp_done = 1'b0;
      #1;
      total++; if ({resp_valid, resp_id, resp_data} !== {1'b1, i[0], exp_data}) begin
        bad++; $display("FAIL contention_resp op %0d got v=%b id=%b d=%h want v=1 id=%b d=%h", i, resp_valid, resp_id, resp_data, i[0], exp_data);
      end
      tick();                       // back to IDLE
    end
    r0_valid = 1'b0; r1_valid = 1'b0;
  endtask

  task automatic test_single();
    r0_valid = 1'b1; r0_a = 32'h3F80_0000; r0_b = 32'h4000_0000;
    #1;
    total++; if ({r0_ready, r1_ready, dp_start} !== 3'b100) begin bad++; $display("FAIL single_grant got %b want 100", {r0_ready, r1_ready, dp_start}); end
    tick();
    r0_valid = 1'b0;
    #1;
    total++; if ({dp_start, r0_ready} !== 2'b10) begin bad++; $display("FAIL single_start got %b want 10", {dp_start, r0_ready}); end
    total++; if ({dp_a, dp_b} !== {32'h3F80_0000, 32'h4000_0000}) begin bad++; $display("FAIL single_operands got %h want 3f80000040000000", {dp_a, dp_b}); end
    tick();
    total++; if (dp_start !== 1'b0) begin bad++; $display("FAIL single_start_pulse got %b want 0", dp_start); end
    repeat (4) tick();              // cycle 6: five cycles after dp_start
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL single_early_resp got %b want 0", resp_valid); end
    dp_done = 1'b1; dp_result = 32'h4040_0000;
    tick();
    dp_done = 1'b0;
    total++; if ({resp_valid, resp_id, resp_err, resp_data} !== {3'b100, 32'h4040_0000}) begin
      bad++; $display("FAIL single_resp got v=%b id=%b e=%b d=%h want v=1 id=0 e=0 d=40400000", resp_valid, resp_id, resp_err, resp_data);
    end
    tick();
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL single_release got %b want 0", resp_valid); end
  endtask

  task automatic test_bypass();
    logic [31:0] va [3] = '{32'h0000_0000, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] vb [3] = '{32'hC0A0_0000, 32'h8000_0000, 32'h0000_0000};
    logic [31:0] ve [3] = '{32'hC0A0_0000, 32'h8000_0000, 32'h0000_0000};
    logic        vid [3] = '{1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 3; i++) begin
      r0_valid = ~vid[i]; r1_valid = vid[i];
      r0_a = va[i]; r0_b = vb[i]; r1_a = va[i]; r1_b = vb[i];
      #1;
      total++; if ({r1_ready, r0_ready} !== {vid[i], ~vid[i]}) begin bad++; $display("FAIL bypass_grant %0d got %b want %b", i, {r1_ready, r0_ready}, {vid[i], ~vid[i]}); end
      tick();
      r0_valid = 1'b0; r1_valid = 1'b0;
      total++; if ({dp_start, resp_valid, resp_id, resp_err, resp_data} !== {2'b01, vid[i], 1'b0, ve[i]}) begin
        bad++; $display("FAIL bypass_resp %0d got s=%b v=%b id=%b e=%b d=%h want s=0 v=1 id=%b e=0 d=%h", i, dp_start, resp_valid, resp_id, resp_err, resp_data, vid[i], ve[i]);
      end
      tick();
    end
  endtask

  task automatic test_timeout();
    for (int k = 0; k < 2; k++) begin
      r0_valid = 1'b1; r0_a = 32'h3F80_0000; r0_b = 32'h3F80_0000;
      tick();
      r0_valid = 1'b0;
      total++; if (dp_start !== 1'b1) begin bad++; $display("FAIL timeout_start %0d got %b want 1", k, dp_start); end
      repeat (63) tick();           // cycle 64: 63 cycles after dp_start
      total++; if ({resp_valid, dp_a} !== {1'b0, 32'h3F80_0000}) begin bad++; $display("FAIL timeout_wait %0d got v=%b a=%h want v=0 a=3f800000", k, resp_valid, dp_a); end
      if (k == 1) begin dp_done = 1'b1; dp_result = 32'h4120_0000; end
      tick();
      dp_done = 1'b0;
      if (k == 0) begin
        total++; if ({resp_valid, resp_err, resp_data} !== {2'b11, 32'h7FC0_0000}) begin
          bad++; $display("FAIL timeout_err got v=%b e=%b d=%h want v=1 e=1 d=7fc00000", resp_valid, resp_err, resp_data);
        end
      end else begin
        total++; if ({resp_valid, resp_err, resp_data} !== {2'b10, 32'h4120_0000}) begin
          bad++; $display("FAIL timeout_race got v=%b e=%b d=%h want v=1 e=0 d=41200000", resp_valid, resp_err, resp_data);
        end
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic ok;
    resp_ready = 1'b0;
    r0_valid = 1'b1; r0_a = 32'h3F80_0000; r0_b = 32'h0000_0000;
    r1_valid = 1'b1; r1_a = 32'h0000_0000; r1_b = 32'h40A0_0000;
    #1;
    total++; if ({r1_ready, r0_ready} !== 2'b10) begin bad++; $display("FAIL bp_first_grant got %b want 10", {r1_ready, r0_ready}); end
    tick();
    for (int c = 0; c < 10; c++) begin
      ok = (resp_valid === 1'b1) && (resp_id === 1'b1) && (resp_err === 1'b0) &&
           (resp_data === 32'h40A0_0000) && (r0_ready === 1'b0) && (r1_ready === 1'b0);
      total++; if (!ok) begin
        bad++; $display("FAIL bp_hold cycle %0d got v=%b id=%b d=%h rdy=%b%b want v=1 id=1 d=40a00000 rdy=00", c, resp_valid, resp_id, resp_data, r1_ready, r0_ready);
      end
      if (c < 9) tick();
    end
    resp_ready = 1'b1;
    tick();
    total++; if ({resp_valid, r0_ready, r1_ready} !== 3'b010) begin bad++; $display("FAIL bp_regrant got %b want 010", {resp_valid, r0_ready, r1_ready}); end
    tick();
    r0_valid = 1'b0; r1_valid = 1'b0;
    total++; if ({resp_valid, resp_id, resp_data} !== {2'b10, 32'h3F80_0000}) begin
      bad++; $display("FAIL bp_second_resp got v=%b id=%b d=%h want v=1 id=0 d=3f800000", resp_valid, resp_id, resp_data);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    r0_valid = 1'b1; r0_a = 32'h4000_0000; r0_b = 32'h4000_0000;
    tick();
    r0_valid = 1'b0;
    tick(); tick();                 // in WAIT
    rst = 1'b1;
    #1;
    total++; if ({dp_start, resp_valid, resp_id, resp_err, r0_ready, r1_ready} !== 6'b0) begin
      bad++; $display("FAIL rst_mid_ctrl got %b want 000000", {dp_start, resp_valid, resp_id, resp_err, r0_ready, r1_ready});
    end
    total++; if ({dp_a, dp_b, resp_data} !== 96'h0) begin bad++; $display("FAIL rst_mid_data got %h want 0", {dp_a, dp_b, resp_data}); end
    tick();
    rst = 1'b0;
    dp_done = 1'b1; dp_result = 32'h4080_0000;
    tick();
    dp_done = 1'b0;
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL rst_stray_done got %b want 0", resp_valid); end
    tick();
    total++; if ({resp_valid, dp_start} !== 2'b00) begin bad++; $display("FAIL rst_stray_later got %b want 00", {resp_valid, dp_start}); end
    r0_valid = 1'b1; r0_a = 32'h0000_0000; r0_b = 32'h3F80_0000;
    r1_valid = 1'b1; r1_a = 32'h4000_0000; r1_b = 32'h4000_0000;
    #1;
    total++; if ({r0_ready, r1_ready} !== 2'b10) begin bad++; $display("FAIL rst_ptr_grant got %b want 10", {r0_ready, r1_ready}); end
    tick();
    r0_valid = 1'b0; r1_valid = 1'b0;
    total++; if ({resp_valid, resp_id, resp_data} !== {2'b10, 32'h3F80_0000}) begin
      bad++; $display("FAIL rst_after_resp got v=%b id=%b d=%h want v=1 id=0 d=3f800000", resp_valid, resp_id, resp_data);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_contention();
    test_single();
    test_bypass();
    test_timeout();
    test_backpressure();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
